// File: rtl/clock_pkg.sv
// Shared definitions for the BCD hours:minutes:seconds clock.
// Mode encodings and per-digit BCD limits.
package clock_pkg;

    typedef enum logic [1:0] {
        MODE_RUN     = 2'd0,
        MODE_SET_HR  = 2'd1,
        MODE_SET_MIN = 2'd2
    } mode_e;

    localparam logic [3:0] DIG_MAX  = 4'd9;
    localparam logic [3:0] TENS_MAX = 4'd5;
    localparam logic [3:0] HR_MAX_T = 4'd2;
    localparam logic [3:0] HR_MAX_U = 4'd3;

endpackage

// File: rtl/bcd_digit_pair.sv
// Two-digit BCD counter with a programmable wrap value and synchronous clear.
// carry_o is combinational so pairs can chain within a single clock cycle.
module bcd_digit_pair
    import clock_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc_i,
    input  logic       clr_i,
    input  logic [3:0] wrap_t_i,
    input  logic [3:0] wrap_u_i,
    output logic [3:0] tens_o,
    output logic [3:0] units_o,
    output logic       carry_o
);

    logic [3:0] tens_q, tens_d;
    logic [3:0] units_q, units_d;
    logic       at_wrap;

    assign at_wrap = (tens_q == wrap_t_i) && (units_q == wrap_u_i);

    always_comb begin
        tens_d  = tens_q;
        units_d = units_q;
        carry_o = 1'b0;
        if (clr_i) begin
            tens_d  = '0;
            units_d = '0;
        end else if (inc_i) begin
            // The wrap test precedes the units rollover so 23 -> 00 wins over 23 -> 24.
            if (at_wrap) begin
                tens_d  = '0;
                units_d = '0;
                carry_o = 1'b1;
            end else if (units_q == DIG_MAX) begin
                units_d = '0;
                tens_d  = tens_q + 4'd1;
            end else begin
                units_d = units_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tens_q  <= '0;
            units_q <= '0;
        end else begin
            tens_q  <= tens_d;
            units_q <= units_d;
        end
    end

    assign tens_o  = tens_q;
    assign units_o = units_q;

endmodule

// File: rtl/bcd_hms_clock.sv
// Time-of-day source: packed BCD hh:mm:ss driven by a second prescaler,
// with key-driven hour/minute set modes.
module bcd_hms_clock
    import clock_pkg::*;
#(
    parameter int unsigned T1S = 50_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_mode,
    input  logic        key_inc,
    output logic [23:0] data,
    output logic [1:0]  mode,
    output logic        sec_tick
);

    localparam int unsigned PW = (T1S > 2) ? $clog2(T1S) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(T1S - 1);

    mode_e         state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          sec_tick_q, sec_tick_d;

    logic          is_run, is_set_hr, is_set_min;
    logic          tick, run_tick;
    logic          set_inc;
    logic          sec_inc, sec_clr, min_inc, hr_inc;
    logic          sec_carry, min_carry;
    logic [3:0]    sec_t, sec_u, min_t, min_u, hr_t, hr_u;

    assign is_run     = (state_q == MODE_RUN);
    assign is_set_hr  = (state_q == MODE_SET_HR);
    assign is_set_min = (state_q == MODE_SET_MIN);

    assign tick     = is_run && (presc_q == PRESC_LAST);
    // A mode change in the same cycle discards the tick and any key_inc.
    assign run_tick = tick && !key_mode;
    assign set_inc  = key_inc && !key_mode;

    assign sec_inc = run_tick;
    assign sec_clr = is_set_min && key_mode;
    assign min_inc = is_run ? sec_carry : (is_set_min && set_inc);
    assign hr_inc  = is_run ? min_carry : (is_set_hr && set_inc);

    always_comb begin
        state_d    = state_q;
        presc_d    = '0;
        sec_tick_d = 1'b0;
        unique case (state_q)
            MODE_RUN: begin
                if (key_mode) begin
                    state_d = MODE_SET_HR;
                end else begin
                    presc_d    = tick ? '0 : presc_q + 1'b1;
                    sec_tick_d = tick;
                end
            end
            MODE_SET_HR: begin
                if (key_mode) state_d = MODE_SET_MIN;
            end
            MODE_SET_MIN: begin
                if (key_mode) state_d = MODE_RUN;
            end
            default: state_d = MODE_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= MODE_RUN;
            presc_q    <= '0;
            sec_tick_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            sec_tick_q <= sec_tick_d;
        end
    end

    bcd_digit_pair u_sec (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc_i    (sec_inc),
        .clr_i    (sec_clr),
        .wrap_t_i (TENS_MAX),
        .wrap_u_i (DIG_MAX),
        .tens_o   (sec_t),
        .units_o  (sec_u),
        .carry_o  (sec_carry)
    );

    bcd_digit_pair u_min (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc_i    (min_inc),
        .clr_i    (1'b0),
        .wrap_t_i (TENS_MAX),
        .wrap_u_i (DIG_MAX),
        .tens_o   (min_t),
        .units_o  (min_u),
        .carry_o  (min_carry)
    );

    bcd_digit_pair u_hr (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc_i    (hr_inc),
        .clr_i    (1'b0),
        .wrap_t_i (HR_MAX_T),
        .wrap_u_i (HR_MAX_U),
        .tens_o   (hr_t),
        .units_o  (hr_u),
        .carry_o  ()
    );

    assign data     = {hr_t, hr_u, min_t, min_u, sec_t, sec_u};
    assign mode     = state_q;
    assign sec_tick = sec_tick_q;

endmodule

// File: tb/tb_bcd_hms_clock.sv
// Scoreboard bench for bcd_hms_clock: a decimal time model pushes expected
// outputs per driven cycle; they are popped and compared after the clock edge.
module tb_bcd_hms_clock;

    localparam int unsigned T1S = 4;

    logic        clk;
    logic        rst_n;
    logic        key_mode;
    logic        key_inc;
    logic [23:0] data;
    logic [1:0]  mode;
    logic        sec_tick;

    typedef struct {
        logic [23:0] data;
        logic [1:0]  mode;
        logic        st;
    } exp_t;

    exp_t sb[$];

    int vectors = 0;
    int errors  = 0;

    int m_h, m_m, m_s, m_presc, m_mode, m_st;

    bcd_hms_clock #(.T1S(T1S)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_mode (key_mode),
        .key_inc  (key_inc),
        .data     (data),
        .mode     (mode),
        .sec_tick (sec_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] t, u;
        t = 4'(v / 10);
        u = 4'(v % 10);
        return {t, u};
    endfunction

    function automatic logic [23:0] model_data();
        return {to_bcd(m_h), to_bcd(m_m), to_bcd(m_s)};
    endfunction

    function automatic logic digits_valid(input logic [23:0] d);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 6; i++)
            if (d[i*4 +: 4] > 4'd9) ok = 1'b0;
        if (d[7:4] > 4'd5 || d[15:12] > 4'd5) ok = 1'b0;
        if ({d[23:20], d[19:16]} > 8'h23) ok = 1'b0;
        return ok;
    endfunction

    task automatic model_reset();
        m_h = 0; m_m = 0; m_s = 0; m_presc = 0; m_mode = 0; m_st = 0;
    endtask

    task automatic model_step(input logic km, input logic ki);
        logic tk;
        tk = (m_mode == 0) && (m_presc == T1S - 1);
        m_st = 0;
        if (km) begin
            if (m_mode == 0) begin
                m_mode = 1; m_presc = 0;
            end else if (m_mode == 1) begin
                m_mode = 2;
            end else begin
                m_mode = 0; m_s = 0; m_presc = 0;
            end
        end else if (m_mode == 0) begin
            if (tk) begin
                m_presc = 0;
                m_st = 1;
                m_s++;
                if (m_s == 60) begin
                    m_s = 0; m_m++;
                    if (m_m == 60) begin
                        m_m = 0; m_h = (m_h + 1) % 24;
                    end
                end
            end else begin
                m_presc++;
            end
        end else if (m_mode == 1 && ki) begin
            m_h = (m_h + 1) % 24;
        end else if (m_mode == 2 && ki) begin
            m_m = (m_m + 1) % 60;
        end
    endtask

    // Called at a negedge; drives one cycle of keys and returns at the next negedge.
    task automatic step(input logic km, input logic ki);
        exp_t e;
        key_mode = km;
        key_inc  = ki;
        model_step(km, ki);
        e.data = model_data();
        e.mode = 2'(m_mode);
        e.st   = 1'(m_st);
        sb.push_back(e);
        @(posedge clk);
        #1;
        key_mode = 1'b0;
        key_inc  = 1'b0;
        e = sb.pop_front();
        check_vec("data", 32'(data), 32'(e.data));
        check_vec("mode", 32'(mode), 32'(e.mode));
        check_vec("sec_tick", 32'(sec_tick), 32'(e.st));
        check_vec("digit_range", 32'(digits_valid(data)), 32'd1);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    task automatic incs(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        key_mode = 1'b0;
        key_inc  = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_vec("reset_data", 32'(data), 32'h000000);
        check_vec("reset_mode", 32'(mode), 32'd0);
        check_vec("reset_tick", 32'(sec_tick), 32'd0);
        rst_n = 1'b1;

        // First ticks at 4, 8, 12 cycles after release.
        idle(3);
        check_vec("pre_first_tick", 32'(sec_tick), 32'd0);
        idle(1);
        check_vec("first_tick", 32'(sec_tick), 32'd1);
        idle(8);
        check_vec("run12_data", 32'(data), 32'h000003);

        // Preload 23:59:58 then roll over midnight.
        step(1'b1, 1'b0);
        incs(23);
        step(1'b1, 1'b0);
        incs(59);
        step(1'b1, 1'b0);
        check_vec("preload_mode", 32'(mode), 32'd0);
        check_vec("preload_sec_clear", 32'(data), 32'h235900);
        idle(58 * T1S);
        check_vec("preload_data", 32'(data), 32'h235958);
        idle(T1S);
        check_vec("pre_midnight", 32'(data), 32'h235959);
        idle(T1S);
        check_vec("midnight_wrap", 32'(data), 32'h000000);

        // Hour set with 25 increments from 00, then a long hold with no ticks.
        step(1'b1, 1'b0);
        check_vec("set_hr_mode", 32'(mode), 32'd1);
        incs(25);
        check_vec("set_hr_25", 32'(data), 32'h010000);
        idle(100);
        check_vec("set_hr_hold", 32'(data), 32'h010000);

        // key_mode and key_inc together: mode change wins.
        step(1'b1, 1'b1);
        check_vec("both_keys_mode", 32'(mode), 32'd2);
        check_vec("both_keys_data", 32'(data), 32'h010000);

        // Minute wrap without hour carry, then back to RUN.
        incs(58);
        step(1'b0, 1'b1);
        check_vec("min_59", 32'(data), 32'h015900);
        step(1'b0, 1'b1);
        check_vec("min_00", 32'(data), 32'h010000);
        step(1'b0, 1'b1);
        check_vec("min_01", 32'(data), 32'h010100);
        step(1'b1, 1'b0);
        check_vec("back_to_run", 32'(mode), 32'd0);
        idle(T1S - 1);
        check_vec("no_early_tick", 32'(sec_tick), 32'd0);
        idle(1);
        check_vec("tick_after_set", 32'(sec_tick), 32'd1);

        // key_mode coinciding with a tick: the tick is discarded.
        idle(T1S - 1);
        step(1'b1, 1'b0);
        check_vec("tick_vs_mode_data", 32'(data), 32'h010101);
        check_vec("tick_vs_mode_tick", 32'(sec_tick), 32'd0);

        // Build 12:45:30 and reset asynchronously in SET_MIN.
        incs(11);
        step(1'b1, 1'b0);
        incs(44);
        step(1'b1, 1'b0);
        idle(30 * T1S);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check_vec("pre_reset_data", 32'(data), 32'h124530);
        check_vec("pre_reset_mode", 32'(mode), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check_vec("async_rst_data", 32'(data), 32'h000000);
        check_vec("async_rst_mode", 32'(mode), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle(2 * T1S);
        check_vec("post_reset_run", 32'(data), 32'h000002);

        check_vec("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/bcd_hms_clock.md
Name: bcd_hms_clock

Overview:
- Time-of-day source for the 6-digit 7-segment display path.
- Keeps hours:minutes:seconds as six packed BCD digits and presents them on a 24-bit bus that feeds the seg7 scanner directly, with no binary-to-BCD conversion stage.
- Two single-cycle key pulses, coming from an upstream debouncer, step through hour/minute set modes and increment the selected field.

Parameters:
- T1S, 50_000_000: clk cycles per second tick. Must be >= 2. Benches override it to a small value.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- key_mode  input  1  one-cycle pulse; advance to the next mode
- key_inc  input  1  one-cycle pulse; increment the field being set
- data  output  24  packed BCD {h10,h1,m10,m1,s10,s1}; [23:20]=h10 … [3:0]=s1
- mode  output  2  current state: 0=RUN, 1=SET_HR, 2=SET_MIN
- sec_tick  output  1  one-cycle pulse when seconds advance in RUN

Behaviour:
- Reset, asynchronous, rst_n low:
  - data=24'h000000, mode=RUN, sec_tick=0, prescaler=0.
  - Release re-enters RUN with the full count cleared.
- Prescaler:
  - Counts 0..T1S-1 in RUN only.
  - At T1S-1 it wraps to 0 and asserts an internal tick for one cycle.
  - In the SET_HR and SET_MIN states it is held at 0.
- Tick in RUN:
  - data and sec_tick update on the clk edge that ends the cycle in which the prescaler = T1S-1.
  - The first tick after reset appears T1S cycles after reset release.
- BCD increment rules, each digit confined to 0-9:
  - s1 9->0 carries into s10. s10 5->0 when s1 wraps carries into m1.
  - Minutes follow the same pattern; m10 5->0 carries into hours.
  - Hours: 23->00 wraps, meaning h10=2 and h1=3 roll to 00. Otherwise h1 9->0 carries into h10.
  - 23:59:59 + tick = 00:00:00.
- FSM transitions, evaluated on key_mode:
  - RUN -> SET_HR.
  - SET_HR -> SET_MIN.
  - SET_MIN -> RUN. On this transition the seconds digits are cleared to 00 and the prescaler restarts from 0.
- SET_HR: key_inc adds 1 hour, 23->00. Minutes and seconds are unchanged. There is no carry into or out of the hour field.
- SET_MIN: key_inc adds 1 minute, 59->00. There is no carry into hours.
- RUN: key_inc is ignored.
- key_mode and key_inc asserted in the same cycle: the mode change wins and key_inc is dropped.
- A tick coinciding with a key_mode press in RUN: the mode change wins. That tick is discarded and time freezes from that cycle.
- Output timing:
  - All outputs are registered, giving 1-cycle latency from a key pulse to the data and mode update.
  - sec_tick is 0 in the SET_HR and SET_MIN states.
- Digit validity:
  - Every data nibble is always in the range 0-9, and s10 and m10 are always <= 5.
  - The hour pair is always <= 23.
  - Verification asserts all of these every cycle.
- Keys are assumed to be clean one-cycle pulses synchronous to clk. Held-high levels are the upstream debouncer's responsibility.

Decomposition:
- Shared package clock_pkg:
  - Mode encodings MODE_RUN, MODE_SET_HR, MODE_SET_MIN.
  - BCD digit limits: DIG_MAX=9, TENS_MAX=5, HR_MAX_T=2, HR_MAX_U=3.
- One sub-module, bcd_digit_pair: a two-digit BCD counter.
  - Inputs: inc, a wrap value, and a synchronous clear.
  - Outputs: the two digits and a carry pulse on wrap.
  - Instantiated three times: seconds (wrap 59), minutes (wrap 59), hours (wrap 23).
  - Mode logic gates the inc and carry paths between the pairs.

Test Plan (T1S=4):
- Reset, then release; run 12 cycles -> data = 24'h000003, with sec_tick pulses at cycles 4, 8 and 12 after release.
- Preload 23:59:58 via the set modes plus ticks; wait 2 ticks -> data goes 24'h235959, then 24'h000000.
- RUN -> key_mode -> SET_HR, then key_inc x25 from 00 -> hours = 01 with minutes and seconds unchanged. No ticks occur and the prescaler stays 0 for 100 cycles.
- SET_MIN at 58: key_inc x3 -> minutes 59, 00, 01, with no hour change. Then key_mode -> mode=RUN, seconds=00, and the first tick arrives 4 cycles later.
- key_mode and key_inc asserted together in SET_HR -> mode=SET_MIN, hours unchanged.
- Assert rst_n low mid-SET_MIN with data=24'h124530 -> data=24'h000000 and mode=RUN immediately, asynchronously, without waiting for a clk edge.
